// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory port (0 = fetch, 1 = load/store).
// Runs one transaction at a time with a bounded ack wait and a one-cycle done pulse to the owner.
module mem_port_arbiter #(
   parameter int n   = 32,
   parameter int AW  = 32,
   parameter int TMO = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [n-1:0]  wdata0,
   input  logic [n-1:0]  wdata1,
   output logic          done0,
   output logic          done1,
   output logic          err,
   output logic [n-1:0]  rdata,
   output logic          sel,
   output logic          busy,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [n-1:0]  mem_wdata,
   input  logic [n-1:0]  mem_rdata,
   input  logic          mem_ack
);

   localparam int            CW       = (TMO > 0) ? $clog2(TMO + 1) : 1;
   localparam bit            TMO_EN   = (TMO > 0);
   localparam logic [CW-1:0] CNT_LAST = CW'((TMO > 0) ? TMO - 1 : 0);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t          state_q;
   logic            sel_q, last_q, busy_q, mem_req_q, mem_we_q;
   logic            done0_q, done1_q, err_q;
   logic [AW-1:0]   mem_addr_q;
   logic [n-1:0]    mem_wdata_q, rdata_q;
   logic [CW-1:0]   cnt_q;

   logic            win_d;
   logic            tmo_d;

   // On a tie the requester that did not own the last transaction wins.
   assign win_d = (req0 && req1) ? ~last_q : req1;
   assign tmo_d = TMO_EN && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         sel_q       <= 1'b0;
         last_q      <= 1'b1;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  state_q     <= REQ;
                  sel_q       <= win_d;
                  busy_q      <= 1'b1;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= win_d ? we1    : we0;
                  mem_addr_q  <= win_d ? addr1  : addr0;
                  mem_wdata_q <= win_d ? wdata1 : wdata0;
                  cnt_q       <= '0;
               end
            end
            REQ: begin
               // An ack in the timeout cycle still counts as a normal completion.
               if (mem_ack || tmo_d) begin
                  state_q   <= DONE;
                  mem_req_q <= 1'b0;
                  err_q     <= ~mem_ack;
                  done0_q   <= ~sel_q;
                  done1_q   <= sel_q;
                  if (mem_ack && !mem_we_q)
                     rdata_q <= mem_rdata;
               end else if (cnt_q != {CW{1'b1}}) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               err_q   <= 1'b0;
               last_q  <= sel_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done0     = done0_q;
   assign done1     = done1_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign sel       = sel_q;
   assign busy      = busy_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule
